// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state encodings, default sizes and divider terminal counts
package freq_meter_pkg;

   // Two-bit encoding leaves room for a future ARM state.
   localparam logic [1:0] FM_IDLE    = 2'd0;
   localparam logic [1:0] FM_MEASURE = 2'd1;

   localparam int FM_CNT_W_DEF   = 24;
   localparam int FM_TIMEOUT_DEF = 16_777_215;
   localparam int FM_SYNC_N_DEF  = 2;

   // Clock divider half-period terminal counts at 100 MHz (output toggles every tc+1 cycles).
   localparam int FM_CLK_HZ      = 100_000_000;
   localparam int FM_DIV_TC_10K  = 4_999;
   localparam int FM_DIV_TC_100  = 499_999;

   function automatic int fm_div_period(input int tc);
      return 2 * (tc + 1);
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-stage synchronizer with registered rising-edge pulse
module sync_edge_det #(
   parameter int SYNC_N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic sig_s,
   output logic rise
);

   logic [SYNC_N-1:0] sync_q;
   logic              sig_s_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         sig_s_d <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_N-2:0], sig_in};
         sig_s_d <= sig_s;
      end
   end

   assign sig_s = sync_q[SYNC_N-1];
   assign rise  = sig_s & ~sig_s_d;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - measures period and high time of a slow input in clk cycles
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int CNT_W   = FM_CNT_W_DEF,
   parameter int TIMEOUT = FM_TIMEOUT_DEF,
   parameter int SYNC_N  = FM_SYNC_N_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             timeout,
   output logic             busy
);

   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   logic             sig_s;
   logic             rise;
   logic [1:0]       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [CNT_W-1:0] hcnt, hcnt_nx;
   logic [CNT_W-1:0] period_nx, high_nx;
   logic             valid_nx, timeout_nx;

   sync_edge_det #(
      .SYNC_N (SYNC_N)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_in (sig_in),
      .sig_s  (sig_s),
      .rise   (rise)
   );

   // Windows open on a rise with both counters at 1 so the opening edge cycle is included.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      hcnt_nx    = hcnt;
      period_nx  = period;
      high_nx    = high_time;
      valid_nx   = 1'b0;
      timeout_nx = 1'b0;
      case (state)
         FM_MEASURE: begin
            if (!en) begin
               state_nx = FM_IDLE;
            end else if (rise) begin
               period_nx = cnt;
               high_nx   = hcnt;
               valid_nx  = 1'b1;
               cnt_nx    = ONE;
               hcnt_nx   = ONE;
            end else if (cnt == TO_CNT) begin
               timeout_nx = 1'b1;
               state_nx   = FM_IDLE;
            end else begin
               cnt_nx  = cnt + ONE;
               hcnt_nx = hcnt + CNT_W'(sig_s);
            end
         end
         default: begin
            if (en && rise) begin
               state_nx = FM_MEASURE;
               cnt_nx   = ONE;
               hcnt_nx  = ONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FM_IDLE;
         cnt       <= '0;
         hcnt      <= '0;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         hcnt      <= hcnt_nx;
         period    <= period_nx;
         high_time <= high_nx;
         valid     <= valid_nx;
         timeout   <= timeout_nx;
      end
   end

   assign busy = (state == FM_MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - randomized self-checking bench for freq_meter against an event-level model
module tb_freq_meter;
   import freq_meter_pkg::*;

   localparam int CW   = 8;
   localparam int TO   = 100;
   localparam int SN   = 2;
   localparam int LAT  = SN + 1;
   localparam int MAXN = 8000;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b1;
   logic          en     = 1'b0;
   logic          sig_in = 1'b0;
   logic [CW-1:0] period, high_time;
   logic          valid, timeout, busy;

   logic          en2  = 1'b0;
   logic          sig2 = 1'b0;
   logic [23:0]   period2, high2;
   logic          valid2, timeout2, busy2;

   always #5 clk = ~clk;

   freq_meter #(.CNT_W(CW), .TIMEOUT(TO), .SYNC_N(SN)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
      .period(period), .high_time(high_time), .valid(valid), .timeout(timeout), .busy(busy)
   );

   freq_meter #(.CNT_W(24), .SYNC_N(2)) dut10k (
      .clk(clk), .rst_n(rst_n), .en(en2), .sig_in(sig2),
      .period(period2), .high_time(high2), .valid(valid2), .timeout(timeout2), .busy(busy2)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   bit          w [MAXN];
   bit          e [MAXN];
   int          n = 0;
   bit          exp_v [MAXN];
   bit          exp_t [MAXN];
   bit          exp_b [MAXN];
   logic [31:0] exp_p [MAXN];
   logic [31:0] exp_h [MAXN];

   task automatic add(input bit v, input bit en_v, input int len);
      for (int i = 0; i < len; i++) begin
         w[n] = v;
         e[n] = en_v;
         n++;
      end
   endtask

   task automatic pulse(input int h, input int l, input bit en_v);
      add(1'b1, en_v, h);
      add(1'b0, en_v, l);
   endtask

   // Reference model: rises of the driven waveform, en seen LAT-1 samples later,
   // period as distance between rises and high time as samples high in between.
   task automatic build_model();
      bit          meas = 1'b0;
      int          s = 0;
      logic [31:0] per = 0, hi = 0;
      for (int i = 0; i < LAT; i++) begin
         exp_v[i] = 0; exp_t[i] = 0; exp_b[i] = 0; exp_p[i] = 0; exp_h[i] = 0;
      end
      for (int k = 0; k + LAT < n; k++) begin
         bit r  = w[k] && (k == 0 || !w[k-1]);
         bit ee = e[k + LAT - 1];
         bit v  = 1'b0;
         bit t  = 1'b0;
         if (!ee) begin
            meas = 1'b0;
         end else if (r) begin
            if (meas) begin
               per = k - s;
               hi  = 0;
               for (int m = s; m < k; m++) hi += w[m];
               v = 1'b1;
            end
            meas = 1'b1;
            s    = k;
         end else if (meas && (k - s) == TO) begin
            t    = 1'b1;
            meas = 1'b0;
         end
         exp_v[k+LAT] = v;
         exp_t[k+LAT] = t;
         exp_b[k+LAT] = meas;
         exp_p[k+LAT] = per;
         exp_h[k+LAT] = hi;
      end
   endtask

   bit stop2 = 1'b0;

   initial begin
      int got, cyc, last, n_to;

      add(1'b0, 1'b1, 4);
      repeat (6) pulse(5, 5, 1'b1);
      repeat (4) pulse(3, 9, 1'b1);
      repeat (4) pulse(9, 3, 1'b1);
      pulse(2, 130, 1'b1);
      repeat (4) pulse(5, 5, 1'b1);
      pulse(40, 60, 1'b1);
      pulse(40, 61, 1'b1);
      repeat (3) pulse(5, 5, 1'b1);
      repeat (2) pulse(5, 5, 1'b1);
      add(1'b1, 1'b1, 3);
      add(1'b1, 1'b0, 4);
      add(1'b0, 1'b0, 5);
      add(1'b1, 1'b0, 5);
      add(1'b1, 1'b1, 2);
      add(1'b0, 1'b1, 5);
      repeat (4) pulse(5, 5, 1'b1);
      repeat (40) pulse($urandom_range(1, 60), $urandom_range(1, 60), $urandom_range(0, 9) != 0);
      repeat (3) pulse(5, 5, 1'b1);
      build_model();

      #1 rst_n = 1'b0;
      #21;
      check("reset_period", 32'(period), 0);
      check("reset_high_time", 32'(high_time), 0);
      check("reset_valid", 32'(valid), 0);
      check("reset_timeout", 32'(timeout), 0);
      check("reset_busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         sig_in = w[i];
         en     = e[i];
         @(negedge clk);
         check($sformatf("valid@%0d", i), 32'(valid), 32'(exp_v[i]));
         check($sformatf("timeout@%0d", i), 32'(timeout), 32'(exp_t[i]));
         check($sformatf("busy@%0d", i), 32'(busy), 32'(exp_b[i]));
         check($sformatf("period@%0d", i), 32'(period), exp_p[i]);
         check($sformatf("high_time@%0d", i), 32'(high_time), exp_h[i]);
      end

      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_period", 32'(period), 0);
      check("async_rst_high_time", 32'(high_time), 0);
      check("async_rst_valid", 32'(valid), 0);
      check("async_rst_timeout", 32'(timeout), 0);
      check("async_rst_busy", 32'(busy), 0);
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      en2 = 1'b1;
      fork
         begin
            while (!stop2) begin
               repeat (FM_DIV_TC_10K + 1) @(posedge clk);
               #1 sig2 = ~sig2;
            end
         end
      join_none
      got = 0; cyc = 0; last = -1; n_to = 0;
      while (got < 3 && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (timeout2) n_to++;
         if (valid2) begin
            check("div10k_period", 32'(period2), 10_000);
            check("div10k_high_time", 32'(high2), 5_000);
            if (last >= 0) check("div10k_interval", cyc - last, fm_div_period(FM_DIV_TC_10K));
            last = cyc;
            got++;
         end
      end
      stop2 = 1'b1;
      check("div10k_results", got, 3);
      check("div10k_no_timeout", n_to, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
